// File: rtl/phase_addr_gen_if.sv
// Control and address bus of the multi-channel phase-offset address generator.
// The master drives the sweep controls and offsets; the slave (the generator)
// returns one registered read address per channel plus the wrap/done flags.
interface phase_addr_gen_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_CH        = 2
) ();
  logic                            en;
  logic [ADDRESS_WIDTH-1:0]        incr;
  logic [ADDRESS_WIDTH-1:0]        limit;
  logic [1:0]                      mode;
  logic                            restart;
  logic                            offset_load;
  logic [NUM_CH*ADDRESS_WIDTH-1:0] offset;
  logic [NUM_CH*ADDRESS_WIDTH-1:0] addr;
  logic                            wrap;
  logic                            done;

  modport master (
    output en, incr, limit, mode, restart, offset_load, offset,
    input  addr, wrap, done
  );

  modport slave (
    input  en, incr, limit, mode, restart, offset_load, offset,
    output addr, wrap, done
  );
endinterface

// File: rtl/phase_addr_gen.sv
// Multi-channel phase-offset address generator.
// A single phase accumulator sweeps 0..limit (wrap-up, wrap-down, one-shot or
// ping-pong); each channel address is the post-update phase plus that
// channel's offset, reduced once modulo limit+1. All sums use AW+1 bits so
// nothing overflows. Outputs are registered: the response to inputs sampled
// at one edge is visible right after that edge.
module phase_addr_gen #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int NUM_CH        = 2
) (
  input  logic             clk,
  input  logic             rst,
  phase_addr_gen_if.slave  bus
);

  localparam int AW = ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    MODE_WRAP_UP   = 2'b00,
    MODE_WRAP_DOWN = 2'b01,
    MODE_ONE_SHOT  = 2'b10,
    MODE_PING_PONG = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // State
  logic [AW-1:0]        phase_r;
  dir_t                 dir_r;
  logic                 done_r;
  logic                 wrap_r;
  logic [AW-1:0]        off_r [NUM_CH];
  logic [NUM_CH*AW-1:0] addr_r;

  // Next-state values
  logic [AW-1:0]        phase_nx_s;
  dir_t                 dir_nx_s;
  logic                 done_nx_s;
  logic                 wrap_nx_s;
  logic [AW-1:0]        off_nx_s [NUM_CH];
  logic [NUM_CH*AW-1:0] addr_nx_s;

  // AW+1-bit arithmetic helpers
  mode_t                mode_s;
  logic [AW:0]          lim_s;
  logic [AW:0]          mod_s;
  logic [AW:0]          step_s;
  logic [AW:0]          sum_s;
  logic [AW:0]          sum_wrap_s;
  logic [AW:0]          dec_s;
  logic [AW:0]          refl_s;
  logic [AW:0]          asum_s [NUM_CH];
  logic [AW:0]          ared_s [NUM_CH];

  assign mode_s     = mode_t'(bus.mode);
  assign lim_s      = {1'b0, bus.limit};
  assign mod_s      = lim_s + {{AW{1'b0}}, 1'b1};
  // Effective step is clamped to the range top so one step never laps twice.
  assign step_s     = (bus.incr < bus.limit) ? {1'b0, bus.incr} : lim_s;
  assign sum_s      = {1'b0, phase_r} + step_s;
  assign sum_wrap_s = sum_s - mod_s;
  assign dec_s      = {1'b0, phase_r} - step_s;
  assign refl_s     = {1'b0, phase_r} + mod_s - step_s;

  // Phase, direction, done and wrap next state: restart beats en.
  always_comb begin
    phase_nx_s = phase_r;
    dir_nx_s   = dir_r;
    done_nx_s  = done_r;
    wrap_nx_s  = 1'b0;
    if (bus.restart) begin
      phase_nx_s = {AW{1'b0}};
      dir_nx_s   = DIR_UP;
      done_nx_s  = 1'b0;
    end else if (bus.en) begin
      if ((mode_s == MODE_ONE_SHOT) && done_r) begin
        // Completed one-shot: en has no effect until restart.
        phase_nx_s = phase_r;
      end else if ({1'b0, phase_r} > lim_s) begin
        // Limit was lowered below the phase: re-enter the range.
        phase_nx_s = (mode_s == MODE_WRAP_DOWN) ? bus.limit : {AW{1'b0}};
        wrap_nx_s  = 1'b1;
      end else begin
        case (mode_s)
          MODE_WRAP_UP: begin
            if (sum_s > lim_s) begin
              phase_nx_s = sum_wrap_s[AW-1:0];
              wrap_nx_s  = 1'b1;
            end else begin
              phase_nx_s = sum_s[AW-1:0];
            end
          end
          MODE_WRAP_DOWN: begin
            if ({1'b0, phase_r} < step_s) begin
              phase_nx_s = refl_s[AW-1:0];
              wrap_nx_s  = 1'b1;
            end else begin
              phase_nx_s = dec_s[AW-1:0];
            end
          end
          MODE_ONE_SHOT: begin
            // limit=0 gives a zero step, yet the single pass is complete.
            if ((sum_s > lim_s) || (bus.limit == {AW{1'b0}})) begin
              phase_nx_s = bus.limit;
              done_nx_s  = 1'b1;
              wrap_nx_s  = 1'b1;
            end else begin
              phase_nx_s = sum_s[AW-1:0];
            end
          end
          MODE_PING_PONG: begin
            if (dir_r == DIR_UP) begin
              if (sum_s > lim_s) begin
                phase_nx_s = bus.limit;
                dir_nx_s   = DIR_DOWN;
                wrap_nx_s  = 1'b1;
              end else begin
                phase_nx_s = sum_s[AW-1:0];
              end
            end else begin
              if ({1'b0, phase_r} < step_s) begin
                phase_nx_s = {AW{1'b0}};
                dir_nx_s   = DIR_UP;
                wrap_nx_s  = 1'b1;
              end else begin
                phase_nx_s = dec_s[AW-1:0];
              end
            end
          end
          default: begin
            phase_nx_s = phase_r;
          end
        endcase
      end
    end else begin
      phase_nx_s = phase_r;
    end
  end

  // Offset capture (clamped to limit) and per-channel address from next-state values.
  always_comb begin
    addr_nx_s = {(NUM_CH*AW){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (bus.offset_load) begin
        off_nx_s[i] = (bus.offset[i*AW +: AW] < bus.limit) ? bus.offset[i*AW +: AW] : bus.limit;
      end else begin
        off_nx_s[i] = off_r[i];
      end
      asum_s[i] = {1'b0, phase_nx_s} + {1'b0, off_nx_s[i]};
      ared_s[i] = asum_s[i] - mod_s;
      if (asum_s[i] > lim_s) begin
        addr_nx_s[i*AW +: AW] = ared_s[i][AW-1:0];
      end else begin
        addr_nx_s[i*AW +: AW] = asum_s[i][AW-1:0];
      end
    end
  end

  // State and output registers; rst overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= {AW{1'b0}};
      dir_r   <= DIR_UP;
      done_r  <= 1'b0;
      wrap_r  <= 1'b0;
      addr_r  <= {(NUM_CH*AW){1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
        off_r[i] <= {AW{1'b0}};
      end
    end else begin
      phase_r <= phase_nx_s;
      dir_r   <= dir_nx_s;
      done_r  <= done_nx_s;
      wrap_r  <= wrap_nx_s;
      addr_r  <= addr_nx_s;
      for (int i = 0; i < NUM_CH; i++) begin
        off_r[i] <= off_nx_s[i];
      end
    end
  end

  assign bus.addr = addr_r;
  assign bus.wrap = wrap_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_phase_addr_gen.sv
// Scoreboard bench for phase_addr_gen: each stimulus cycle pushes the
// expected registered response (from an arithmetic reference model, plus
// optional hand-derived values) and a monitor pops and compares after the edge.
module tb_phase_addr_gen;
  localparam int AW  = 8;
  localparam int NCH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  phase_addr_gen_if #(.ADDRESS_WIDTH(AW), .NUM_CH(NCH)) bus ();

  phase_addr_gen #(.ADDRESS_WIDTH(AW), .NUM_CH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [NCH*AW-1:0] a;
    logic              w;
    logic              d;
    logic              va;
    logic [31:0]       x0;
    logic [31:0]       x1;
    logic [31:0]       xw;
    logic [31:0]       xd;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_p;
  int m_off [NCH];
  bit m_up;
  bit m_done;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Drive one cycle, advance the model, queue the expected response.
  task automatic cyc(input bit r, input bit e, input bit rs, input bit ol,
                     input logic [1:0] m, input int inc, input int lim,
                     input int x0 = -1, input int x1 = -1,
                     input int xw = -1, input int xd = -1);
    exp_t          x;
    int            s;
    int            ov;
    logic [AW-1:0] t;
    bit            w;
    rst             = r;
    bus.en          = e;
    bus.restart     = rs;
    bus.offset_load = ol;
    bus.mode        = m;
    bus.incr        = inc[AW-1:0];
    bus.limit       = lim[AW-1:0];
    s = (inc < lim) ? inc : lim;
    w = 1'b0;
    if (r) begin
      m_p = 0; m_up = 1'b1; m_done = 1'b0;
      for (int i = 0; i < NCH; i++) m_off[i] = 0;
    end else begin
      if (ol) begin
        for (int i = 0; i < NCH; i++) begin
          ov = int'(bus.offset[i*AW +: AW]);
          m_off[i] = (ov < lim) ? ov : lim;
        end
      end
      if (rs) begin
        m_p = 0; m_up = 1'b1; m_done = 1'b0;
      end else if (e) begin
        if (m == 2'b10 && m_done) begin
          m_p = m_p;
        end else if (m_p > lim) begin
          m_p = (m == 2'b01) ? lim : 0;
          w = 1'b1;
        end else begin
          case (m)
            2'b00: begin
              w   = (m_p + s) > lim;
              m_p = (m_p + s) % (lim + 1);
            end
            2'b01: begin
              w   = m_p < s;
              m_p = (m_p - s + lim + 1) % (lim + 1);
            end
            2'b10: begin
              if ((m_p + s > lim) || lim == 0) begin
                m_p = lim; m_done = 1'b1; w = 1'b1;
              end else m_p = m_p + s;
            end
            default: begin
              if (m_up) begin
                if (m_p + s > lim) begin m_p = lim; m_up = 1'b0; w = 1'b1; end
                else m_p = m_p + s;
              end else begin
                if (m_p < s) begin m_p = 0; m_up = 1'b1; w = 1'b1; end
                else m_p = m_p - s;
              end
            end
          endcase
        end
      end
    end
    x.va = (m_p <= lim);
    for (int i = 0; i < NCH; i++) begin
      if (m_off[i] > lim) x.va = 1'b0;
      t = AW'((m_p + m_off[i]) % (lim + 1));
      x.a[i*AW +: AW] = t;
    end
    x.w  = w;
    x.d  = m_done;
    x.x0 = x0;
    x.x1 = x1;
    x.xw = xw;
    x.xd = xd;
    sb_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: compare the registered outputs shortly after each edge.
  always @(posedge clk) begin
    exp_t ex;
    #2;
    if (sb_q.size() > 0) begin
      ex = sb_q.pop_front();
      if (ex.va) begin
        for (int i = 0; i < NCH; i++)
          chk($sformatf("addr%0d", i), int'(bus.addr[i*AW +: AW]), int'(ex.a[i*AW +: AW]));
      end
      chk("wrap", int'(bus.wrap), int'(ex.w));
      chk("done", int'(bus.done), int'(ex.d));
      if (ex.x0 != 32'hFFFF_FFFF) chk("plan_ch0", int'(bus.addr[AW-1:0]), int'(ex.x0));
      if (ex.x1 != 32'hFFFF_FFFF) chk("plan_ch1", int'(bus.addr[2*AW-1:AW]), int'(ex.x1));
      if (ex.xw != 32'hFFFF_FFFF) chk("plan_wrap", int'(bus.wrap), int'(ex.xw));
      if (ex.xd != 32'hFFFF_FFFF) chk("plan_done", int'(bus.done), int'(ex.xd));
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #1_000_000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int            lim_r;
    logic [1:0]    mode_r;
    bus.en = 1'b0; bus.restart = 1'b0; bus.offset_load = 1'b0;
    bus.mode = 2'b00; bus.incr = '0; bus.limit = '0; bus.offset = '0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 2'b00, 3, 9, 0, 0, 0, 0);

    // Wrap-up, limit 9, incr 3, offsets {0,5}
    bus.offset = {8'd5, 8'd0};
    cyc(0, 0, 0, 1, 2'b00, 3, 9, 0, 5, 0);
    cyc(0, 1, 0, 0, 2'b00, 3, 9, 3, 8, 0);
    cyc(0, 1, 0, 0, 2'b00, 3, 9, 6, 1, 0);
    cyc(0, 1, 0, 0, 2'b00, 3, 9, 9, 4, 0);
    cyc(0, 1, 0, 0, 2'b00, 3, 9, 2, 7, 1);
    cyc(0, 1, 0, 0, 2'b00, 3, 9, 5, 0, 0);

    // Wrap-down, limit 255, incr 1
    cyc(1, 0, 0, 0, 2'b01, 1, 255, 0, 0, 0);
    cyc(0, 1, 0, 0, 2'b01, 1, 255, 255, -1, 1);
    cyc(0, 1, 0, 0, 2'b01, 1, 255, 254, -1, 0);

    // Ping-pong, limit 7, incr 3
    cyc(1, 0, 0, 0, 2'b11, 3, 7, 0, -1, 0);
    cyc(0, 1, 0, 0, 2'b11, 3, 7, 3, -1, 0);
    cyc(0, 1, 0, 0, 2'b11, 3, 7, 6, -1, 0);
    cyc(0, 1, 0, 0, 2'b11, 3, 7, 7, -1, 1);
    cyc(0, 1, 0, 0, 2'b11, 3, 7, 4, -1, 0);
    cyc(0, 1, 0, 0, 2'b11, 3, 7, 1, -1, 0);
    cyc(0, 1, 0, 0, 2'b11, 3, 7, 0, -1, 1);
    cyc(0, 1, 0, 0, 2'b11, 3, 7, 3, -1, 0);

    // One-shot, limit 10, incr 4
    cyc(1, 0, 0, 0, 2'b10, 4, 10, 0, -1, 0, 0);
    cyc(0, 1, 0, 0, 2'b10, 4, 10, 4, -1, 0, 0);
    cyc(0, 1, 0, 0, 2'b10, 4, 10, 8, -1, 0, 0);
    cyc(0, 1, 0, 0, 2'b10, 4, 10, 10, -1, 1, 1);
    cyc(0, 1, 0, 0, 2'b10, 4, 10, 10, -1, 0, 1);
    cyc(0, 1, 0, 0, 2'b10, 4, 10, 10, -1, 0, 1);
    cyc(0, 0, 1, 0, 2'b10, 4, 10, 0, -1, 0, 0);

    // One-shot with limit 0 completes on the first en
    cyc(0, 1, 0, 0, 2'b10, 5, 0, 0, -1, 1, 1);

    // Simultaneous events
    cyc(1, 0, 0, 0, 2'b00, 1, 9, 0, 0, 0);
    cyc(0, 1, 0, 0, 2'b00, 1, 9, 1, 1, 0);
    cyc(0, 1, 0, 0, 2'b00, 1, 9, 2, 2, 0);
    cyc(0, 1, 0, 0, 2'b00, 1, 9, 3, 3, 0);
    bus.offset = {8'd7, 8'd2};
    cyc(0, 1, 0, 1, 2'b00, 1, 9, 6, 1, 0);
    cyc(0, 1, 1, 0, 2'b00, 1, 9, 2, 7, 0);
    cyc(1, 1, 1, 1, 2'b00, 1, 9, 0, 0, 0, 0);

    // Limit shrink below the phase
    bus.offset = '0;
    cyc(1, 0, 0, 0, 2'b00, 200, 255, 0, 0, 0);
    cyc(0, 1, 0, 0, 2'b00, 200, 255, 200, -1, 0);
    cyc(0, 1, 0, 0, 2'b00, 1, 50, 0, -1, 1);
    cyc(0, 1, 0, 0, 2'b00, 1, 50, 1, -1, 0);
    cyc(0, 1, 0, 0, 2'b00, 1, 50, 2, -1, 0);

    // Randomized traffic against the model
    lim_r  = 9;
    mode_r = 2'b00;
    for (int k = 0; k < 2000; k++) begin
      bit r, e, rs, ol;
      int inc;
      r  = ($urandom_range(0, 199) == 0);
      rs = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 3) != 0);
      ol = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 29) == 0) mode_r = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) begin
        lim_r = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, 255);
        ol = 1'b1;
        if (!rs && !r) e = 1'b1;
      end
      inc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, lim_r + 1);
      for (int i = 0; i < NCH; i++) bus.offset[i*AW +: AW] = AW'($urandom);
      cyc(r, e, rs, ol, mode_r, inc, lim_r);
    end

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual %0d pending required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_addr_gen.md
# phase_addr_gen

Multi-channel phase-offset address generator. One shared phase accumulator steps by a programmable increment within a programmable modulus. It drives NUM_CH registered ROM/RAM read addresses, each displaced by its own loadable phase offset. It supports wrap-up, wrap-down, one-shot and ping-pong sweep modes, so waveform-ROM readers can produce multi-phase, reversed, single-pass or triangle-scanned outputs without external glue.

## Interface
- ADDRESS_WIDTH, 8, width of phase, increment, limit, offsets and addresses (AW below)
- NUM_CH, 2, number of address channels (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  advance phase by one step this cycle
- incr  in  AW  step size; effective step = min(incr, limit)
- limit  in  AW  top of range; phase/addresses span 0..limit (modulus limit+1, computed in AW+1 bits)
- mode  in  2  00 wrap-up, 01 wrap-down, 10 one-shot up, 11 ping-pong
- restart  in  1  phase←0, dir←up, done←0
- offset_load  in  1  capture offset bus
- offset  in  NUM_CH*AW  channel i offset at bits [i*AW +: AW]
- addr  out  NUM_CH*AW  channel i address at bits [i*AW +: AW]
- wrap  out  1  one-cycle pulse: phase wrapped, reflected, or one-shot reached limit
- done  out  1  one-shot complete (sticky)

## Operation
- State: phase p (AW), dir (up/down), done, offset regs off_i, addr regs, wrap reg.
- Priority: rst > restart > en. restart and en in the same cycle: restart wins, en ignored.
- offset_load is independent of restart/en and applies in the same cycle. Captured off_i = min(offset_i, limit).
- Step s = min(incr, limit); all sums in AW+1 bits, no overflow.
- When en=1 and p > limit (limit lowered mid-run): p←0 (wrap-down: p←limit), wrap pulses, normal step skipped.
- Wrap-up: t=p+s; if t>limit, p←t−(limit+1), wrap=1; else p←t.
- Wrap-down: if p<s, p←p+(limit+1)−s, wrap=1; else p←p−s.
- One-shot: while done=0, as wrap-up but t>limit gives p←limit, done←1, wrap=1. While done=1, en ignored and p holds.
- Ping-pong:
  - dir up: t>limit gives p←limit, dir←down, wrap=1.
  - dir down: p<s gives p←0, dir←up, wrap=1.
  - Otherwise step normally.
- Non-ping-pong modes do not alter dir. A mode change takes effect on the next en. done clears only on restart/rst.
- addr_i = (p' + off_i') reduced once mod (limit+1), where p' and off_i' are the post-update values.
- addr_i is defined only while p ≤ limit.
- s=0 (incr=0 or limit=0): p holds, no wrap pulse. Exception: one-shot with limit=0 sets done and pulses wrap on the first en.

## Timing
- Reset values: p=0, dir=up, done=0, off_i=0, every addr_i=0, wrap=0.
- addr, wrap and done are registered. The response to en/restart/offset_load sampled at edge k is visible after edge k (latency 1).
- addr is recomputed every cycle from the next-state p and offsets.
- wrap is high for exactly the one cycle following the qualifying edge; it is low otherwise, including while en is held in one-shot done.
- rst mid-sweep: all state returns to reset values at that edge, regardless of en/restart/offset_load.

## Test plan
- Wrap-up: limit=9, incr=3, offsets {0,5}, en held from reset.
  - Required: ch0 = 0,3,6,9,2 with wrap on the 9→2 step; ch1 = 5,8,1,4,7.
- Wrap-down: limit=255, incr=1, en one cycle after reset.
  - Required: p=255, wrap=1 for one cycle; next en gives 254, wrap=0.
- Ping-pong: limit=7, incr=3.
  - Required: p = 0,3,6,7(wrap),4,1,0(wrap),3.
- One-shot: limit=10, incr=4.
  - Required: p = 0,4,8,10 with done=1 and wrap once.
  - Further en: p stays 10, no wrap.
  - restart: p=0, done=0.
- Simultaneous events:
  - offset_load {2,7} with en at p=3, limit=9, incr=1: ch0=6, ch1=1.
  - restart+en together: p=0.
  - rst+restart+en+offset_load: all outputs 0.
- Limit shrink: p=200, limit changed to 50, en → p=0, wrap=1, then 1,2,…
